// File: rtl/sobel_pkg.sv
// Shared widths, window tap offsets and types for the Sobel Gx engine.
package sobel_pkg;

    localparam int unsigned PIXEL_W  = 8;
    localparam int unsigned OUT_W    = 16;
    localparam int unsigned NUM_TAPS = 9;
    localparam int unsigned WIN_W    = NUM_TAPS * PIXEL_W;
    // a + 2b + c of three PIXEL_W values needs PIXEL_W+2 bits; one spare keeps it 11 wide
    localparam int unsigned SUM_W    = PIXEL_W + 3;

    // Bit offsets of each tap in the row-major window, p0 at the MSBs
    localparam int unsigned P0 = 8 * PIXEL_W;
    localparam int unsigned P1 = 7 * PIXEL_W;
    localparam int unsigned P2 = 6 * PIXEL_W;
    localparam int unsigned P3 = 5 * PIXEL_W;
    localparam int unsigned P4 = 4 * PIXEL_W;
    localparam int unsigned P5 = 3 * PIXEL_W;
    localparam int unsigned P6 = 2 * PIXEL_W;
    localparam int unsigned P7 = 1 * PIXEL_W;
    localparam int unsigned P8 = 0;

    typedef logic [PIXEL_W-1:0]       pixel_t;
    typedef logic [SUM_W-1:0]         colsum_t;
    typedef logic [WIN_W-1:0]         window_t;
    typedef logic signed [OUT_W-1:0]  grad_t;

    // Extract one pixel from a packed window at a tap offset
    function automatic pixel_t tap(input window_t w, input int unsigned off);
        return w[off +: PIXEL_W];
    endfunction

endpackage

// File: rtl/sobel_col_sum.sv
// Weighted column sum a + 2*b + c used for the left and right Sobel columns.
module sobel_col_sum
    import sobel_pkg::*;
(
    input  pixel_t  a_i,
    input  pixel_t  b_i,
    input  pixel_t  c_i,
    output colsum_t sum_c_o
);

    // Zero-extend each pixel before summing so no carry is lost
    always_comb begin
        sum_c_o = SUM_W'(a_i) + (SUM_W'(b_i) << 1) + SUM_W'(c_i);
    end

endmodule

// File: rtl/sobel_compute_engine.sv
// Three-stage pipelined Sobel horizontal-gradient engine, one window per cycle.
module sobel_compute_engine
    import sobel_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    valid_in,
    input  logic [WIN_W-1:0]        pixels_3x3,
    output logic                    valid_out,
    output logic signed [OUT_W-1:0] gradient_x,
    output logic                    busy
);

    window_t window_q, window_d;
    logic    s1_valid_q, s1_valid_d;
    colsum_t right_q, right_d;
    colsum_t left_q, left_d;
    logic    s2_valid_q, s2_valid_d;
    grad_t   grad_q, grad_d;
    logic    s3_valid_q, s3_valid_d;
    logic    valid_out_q, valid_out_d;
    logic    busy_q;
    colsum_t right_sum;
    colsum_t left_sum;

    sobel_col_sum u_right_col (
        .a_i     (tap(window_q, P2)),
        .b_i     (tap(window_q, P5)),
        .c_i     (tap(window_q, P8)),
        .sum_c_o (right_sum)
    );

    sobel_col_sum u_left_col (
        .a_i     (tap(window_q, P0)),
        .b_i     (tap(window_q, P3)),
        .c_i     (tap(window_q, P6)),
        .sum_c_o (left_sum)
    );

    // Next-state: every stage holds unless enable; valid_out only pulses on an advancing edge
    always_comb begin
        window_d    = window_q;
        s1_valid_d  = s1_valid_q;
        right_d     = right_q;
        left_d      = left_q;
        s2_valid_d  = s2_valid_q;
        grad_d      = grad_q;
        s3_valid_d  = s3_valid_q;
        valid_out_d = 1'b0;
        if (enable) begin
            if (valid_in) begin
                window_d = pixels_3x3;
            end
            s1_valid_d  = valid_in;
            right_d     = right_sum;
            left_d      = left_sum;
            s2_valid_d  = s1_valid_q;
            s3_valid_d  = s2_valid_q;
            valid_out_d = s2_valid_q;
            // gradient_x keeps its last result when no window completes
            if (s2_valid_q) begin
                grad_d = grad_t'(OUT_W'(right_q) - OUT_W'(left_q));
            end
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            window_q    <= '0;
            s1_valid_q  <= 1'b0;
            right_q     <= '0;
            left_q      <= '0;
            s2_valid_q  <= 1'b0;
            grad_q      <= '0;
            s3_valid_q  <= 1'b0;
            valid_out_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            window_q    <= window_d;
            s1_valid_q  <= s1_valid_d;
            right_q     <= right_d;
            left_q      <= left_d;
            s2_valid_q  <= s2_valid_d;
            grad_q      <= grad_d;
            s3_valid_q  <= s3_valid_d;
            valid_out_q <= valid_out_d;
            busy_q      <= s1_valid_d | s2_valid_d | s3_valid_d;
        end
    end

    assign valid_out  = valid_out_q;
    assign gradient_x = grad_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sobel_compute_engine.sv
// Self-checking bench for sobel_compute_engine: directed cases plus randomized traffic.
module tb_sobel_compute_engine;

    logic               clk;
    logic               rst;
    logic               enable;
    logic               valid_in;
    logic [71:0]        pixels_3x3;
    logic               valid_out;
    logic signed [15:0] gradient_x;
    logic               busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: each accepted window carries its Gx and the number of
    // enabled edges it has seen; it is delivered at age 2 and leaves at age 3.
    int age_q[$];
    int gx_q[$];
    int last_gx = 0;
    bit exp_vo  = 1'b0;
    logic [15:0] seen_q[$];

    sobel_compute_engine dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .valid_in   (valid_in),
        .pixels_3x3 (pixels_3x3),
        .valid_out  (valid_out),
        .gradient_x (gradient_x),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] mk(input int a, input int b, input int c,
                                       input int d, input int e, input int f,
                                       input int g, input int h, input int i);
        return {8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
    endfunction

    // Gx straight from the kernel definition on pixel values
    function automatic int ref_gx(input logic [71:0] w);
        int p[9];
        for (int k = 0; k < 9; k++) p[k] = int'(w[(8-k)*8 +: 8]);
        return (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive, advance model on the edge, compare outputs 1 ns later
    task automatic cycle(input bit rs, input bit en, input bit vin, input logic [71:0] win);
        int n_age[$];
        int n_gx[$];
        rst        = rs;
        enable     = en;
        valid_in   = vin;
        pixels_3x3 = win;
        @(posedge clk);
        exp_vo = 1'b0;
        if (rs) begin
            age_q.delete();
            gx_q.delete();
            last_gx = 0;
        end else if (en) begin
            for (int k = 0; k < age_q.size(); k++) begin
                if (age_q[k] + 1 < 3) begin
                    n_age.push_back(age_q[k] + 1);
                    n_gx.push_back(gx_q[k]);
                    if (age_q[k] + 1 == 2) begin
                        exp_vo  = 1'b1;
                        last_gx = gx_q[k];
                    end
                end
            end
            if (vin) begin
                n_age.push_back(0);
                n_gx.push_back(ref_gx(win));
            end
            age_q = n_age;
            gx_q  = n_gx;
        end
        #1;
        chk("valid_out", 32'(valid_out), 32'(exp_vo));
        chk("busy", 32'(busy), 32'(age_q.size() != 0));
        chk("gradient_x", 32'(gradient_x), 32'(16'(last_gx)));
        if (valid_out === 1'b1) seen_q.push_back(gradient_x);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, 1'b0, 72'(0));
    endtask

    logic [71:0] w_edge, w_ramp, w_mirr, w_flat;

    initial begin
        w_edge = mk(0, 0, 255, 0, 0, 255, 0, 0, 255);
        w_ramp = mk(10, 20, 30, 40, 50, 60, 70, 80, 90);
        w_mirr = mk(30, 20, 10, 60, 50, 40, 90, 80, 70);
        w_flat = mk(128, 128, 128, 128, 128, 128, 128, 128, 128);
        rst = 1'b1; enable = 1'b0; valid_in = 1'b0; pixels_3x3 = '0;

        // Reset held for five cycles
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0, 72'(0));

        // Vertical edge
        seen_q.delete();
        cycle(1'b0, 1'b1, 1'b1, w_edge);
        idle(5);
        chk("edge_count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() > 0) chk("edge_value", 32'(seen_q[0]), 32'h03FC);

        // Smooth ramp and its mirror
        seen_q.delete();
        cycle(1'b0, 1'b1, 1'b1, w_ramp);
        idle(4);
        cycle(1'b0, 1'b1, 1'b1, w_mirr);
        idle(4);
        chk("ramp_count", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() > 1) begin
            chk("ramp_value", 32'(seen_q[0]), 32'h0050);
            chk("mirror_value", 32'(seen_q[1]), 32'hFFB0);
        end

        // Back-to-back windows
        seen_q.delete();
        cycle(1'b0, 1'b1, 1'b1, w_edge);
        cycle(1'b0, 1'b1, 1'b1, w_ramp);
        cycle(1'b0, 1'b1, 1'b0, 72'(0));
        chk("b2b_busy_mid", 32'(busy), 32'd1);
        idle(4);
        chk("b2b_count", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() > 1) begin
            chk("b2b_first", 32'(seen_q[0]), 32'h03FC);
            chk("b2b_second", 32'(seen_q[1]), 32'h0050);
        end

        // Enable stall with a window in flight; valid_in during the stall is ignored
        seen_q.delete();
        cycle(1'b0, 1'b1, 1'b1, w_ramp);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, w_edge);
        chk("stall_no_out", 32'(seen_q.size()), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        idle(5);
        chk("stall_count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() > 0) chk("stall_value", 32'(seen_q[0]), 32'h0050);

        // Flat window gives zero
        seen_q.delete();
        cycle(1'b0, 1'b1, 1'b1, w_flat);
        idle(4);
        chk("flat_count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() > 0) chk("flat_value", 32'(seen_q[0]), 32'h0000);

        // Reset while a window is in flight discards it
        seen_q.delete();
        cycle(1'b0, 1'b1, 1'b1, w_edge);
        cycle(1'b0, 1'b1, 1'b0, 72'(0));
        cycle(1'b1, 1'b1, 1'b0, 72'(0));
        chk("midrst_busy", 32'(busy), 32'd0);
        idle(5);
        chk("midrst_count", 32'(seen_q.size()), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [71:0] w;
            w = {$urandom(), $urandom(), $urandom()};
            cycle($urandom_range(99) < 2, $urandom_range(99) < 80,
                  $urandom_range(99) < 60, w);
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
